// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2s_pkg
// Description : Shared constants, sample-pair type and slot-size helper for
//               the I2S transmit controller.
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    localparam int CNT_W        = 11;
    localparam int MAX_SAMPLE_W = 32;

    // Samples are stored left-justified so one type covers any width up to 32
    typedef struct packed {
        logic [MAX_SAMPLE_W-1:0] left;
        logic [MAX_SAMPLE_W-1:0] right;
    } sample_pair_t;

    function automatic int slot_bits(input int div_lrck, input int div_sclk);
        return div_lrck / (2 * div_sclk);
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_tx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tx_ctrl_if
// Description : Valid/ready sample-pair stream into the I2S transmit controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2s_tx_ctrl_if #(
    parameter int SAMPLE_WIDTH = 24
);
    logic                    s_valid;
    logic                    s_ready;
    logic [SAMPLE_WIDTH-1:0] s_left;
    logic [SAMPLE_WIDTH-1:0] s_right;

    modport master (output s_valid, output s_left, output s_right, input  s_ready);
    modport slave  (input  s_valid, input  s_left, input  s_right, output s_ready);
endinterface
`default_nettype wire

// File: rtl/i2s_frame_timer.sv
`default_nettype none
// ============================================================================
// Module      : i2s_frame_timer
// Description : Free-running MCLK frame counter with registered LRCK/SCLK and
//               next-cycle bit-index decode for the serialiser.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_frame_timer
    import i2s_pkg::*;
#(
    parameter int MCLK_DIV_LRCK = 256,
    parameter int MCLK_DIV_SCLK = 4
) (
    input  wire logic             mclk,
    input  wire logic             arstn,
    output logic                  lrck,
    output logic                  sclk,
    output logic                  frame_last,
    output logic                  bit_load,
    output logic [CNT_W-1:0]      bit_next
);
    localparam logic [CNT_W-1:0] C_LAST       = CNT_W'(MCLK_DIV_LRCK - 1);
    localparam logic [CNT_W-1:0] C_HALF_FRAME = CNT_W'(MCLK_DIV_LRCK / 2);
    localparam logic [CNT_W-1:0] C_DIV_SCLK   = CNT_W'(MCLK_DIV_SCLK);
    localparam logic [CNT_W-1:0] C_HALF_SCLK  = CNT_W'(MCLK_DIV_SCLK / 2);

    logic [CNT_W-1:0] r_mc;
    logic [CNT_W-1:0] w_mc_next;
    logic [CNT_W-1:0] w_phase_next;

    always_comb begin
        w_mc_next    = (r_mc == C_LAST) ? '0 : r_mc + CNT_W'(1);
        w_phase_next = w_mc_next % C_DIV_SCLK;
    end

    assign frame_last = (r_mc == C_LAST);
    assign bit_load   = (w_phase_next == '0);
    assign bit_next   = w_mc_next / C_DIV_SCLK;

    // Pins are decoded from the next count so they line up with r_mc
    always_ff @(posedge mclk or negedge arstn) begin
        if (!arstn) begin
            r_mc <= '0;
            lrck <= 1'b0;
            sclk <= 1'b0;
        end else begin
            r_mc <= w_mc_next;
            lrck <= (w_mc_next >= C_HALF_FRAME);
            sclk <= (w_phase_next >= C_HALF_SCLK);
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2s_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tx_ctrl
// Description : Stereo Philips-I2S transmitter: one-deep pair buffer, frame
//               register and MSB-first serialiser. Optional macro
//               I2S_TX_REPEAT_ON_UNDERRUN_EN repeats the last pair on underrun.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx_ctrl
    import i2s_pkg::*;
#(
    parameter int MCLK_DIV_LRCK = 256,
    parameter int MCLK_DIV_SCLK = 4,
    parameter int SAMPLE_WIDTH  = 24
) (
    input  wire logic       mclk,
    input  wire logic       arstn,
    i2s_tx_ctrl_if.slave    s,
    output logic            lrck,
    output logic            sclk,
    output logic            sdata,
    output logic            underrun
);
    localparam int               SLOT    = slot_bits(MCLK_DIV_LRCK, MCLK_DIV_SCLK);
    localparam int               IDX_W   = $clog2(MAX_SAMPLE_W);
    localparam logic [CNT_W-1:0] C_SLOT  = CNT_W'(SLOT);
    localparam logic [CNT_W-1:0] C_SW    = CNT_W'(SAMPLE_WIDTH);
    localparam logic [CNT_W-1:0] C_MAXW  = CNT_W'(MAX_SAMPLE_W);

    logic                w_frame_last;
    logic                w_bit_load;
    logic [CNT_W-1:0]    w_bit_next;
    logic                w_handshake;
    sample_pair_t        w_in_pair;
    logic [CNT_W-1:0]    w_pos;
    logic [MAX_SAMPLE_W-1:0] w_chan;
    logic [IDX_W-1:0]    w_idx;
    logic                w_bit;

    logic                r_buf_full;
    sample_pair_t        r_buf_pair;
    sample_pair_t        r_frame;
    logic                r_sdata;
    logic                r_underrun;

    i2s_frame_timer #(
        .MCLK_DIV_LRCK (MCLK_DIV_LRCK),
        .MCLK_DIV_SCLK (MCLK_DIV_SCLK)
    ) u_timer (
        .mclk       (mclk),
        .arstn      (arstn),
        .lrck       (lrck),
        .sclk       (sclk),
        .frame_last (w_frame_last),
        .bit_load   (w_bit_load),
        .bit_next   (w_bit_next)
    );

    assign s.s_ready   = !r_buf_full;
    assign w_handshake = s.s_valid && !r_buf_full;

    always_comb begin
        w_in_pair.left  = MAX_SAMPLE_W'(s.s_left)  << (MAX_SAMPLE_W - SAMPLE_WIDTH);
        w_in_pair.right = MAX_SAMPLE_W'(s.s_right) << (MAX_SAMPLE_W - SAMPLE_WIDTH);
    end

    // Slot position 0 is the one-bit I2S delay; positions past the sample are padding
    always_comb begin
        w_pos  = w_bit_next;
        w_chan = r_frame.left;
        if (w_bit_next >= C_SLOT) begin
            w_pos  = w_bit_next - C_SLOT;
            w_chan = r_frame.right;
        end
        w_idx = IDX_W'(C_MAXW - w_pos);
        w_bit = 1'b0;
        if ((w_pos != '0) && (w_pos <= C_SW)) begin
            w_bit = w_chan[w_idx];
        end
    end

    always_ff @(posedge mclk or negedge arstn) begin
        if (!arstn) begin
            r_buf_full <= 1'b0;
            r_buf_pair <= '0;
            r_frame    <= '0;
            r_sdata    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_frame_last) begin
                if (r_buf_full) begin
                    r_frame    <= r_buf_pair;
                    r_buf_full <= 1'b0;
                end else if (w_handshake) begin
                    r_frame <= w_in_pair;
                end else begin
                    r_underrun <= 1'b1;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
                    r_frame <= r_frame;
`else
                    r_frame <= '0;
`endif
                end
            end else if (w_handshake) begin
                r_buf_pair <= w_in_pair;
                r_buf_full <= 1'b1;
            end
            if (w_bit_load) begin
                r_sdata <= w_bit;
            end
        end
    end

    assign sdata    = r_sdata;
    assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_tx_ctrl
// Description : Self-checking bench for i2s_tx_ctrl against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tx_ctrl;
    localparam int LRCK = 256;
    localparam int SDIV = 4;
    localparam int SW   = 24;
    localparam int SLOT = LRCK / (2 * SDIV);
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    localparam bit REPEAT = 1'b1;
`else
    localparam bit REPEAT = 1'b0;
`endif

    typedef struct packed { logic [SW-1:0] l; logic [SW-1:0] r; } pair_t;
    typedef struct { int mc; bit exp; string nm; } vec_t;

    logic mclk = 1'b0;
    logic arstn;
    logic lrck, sclk, sdata, underrun;
    int   vectors = 0;
    int   errs    = 0;

    i2s_tx_ctrl_if #(.SAMPLE_WIDTH(SW)) sif ();

    i2s_tx_ctrl #(
        .MCLK_DIV_LRCK (LRCK),
        .MCLK_DIV_SCLK (SDIV),
        .SAMPLE_WIDTH  (SW)
    ) dut (
        .mclk     (mclk),
        .arstn    (arstn),
        .s        (sif),
        .lrck     (lrck),
        .sclk     (sclk),
        .sdata    (sdata),
        .underrun (underrun)
    );

    always #5 mclk = ~mclk;

    // Frame-level model: accepted pairs queue up (depth one), each frame takes the head
    pair_t q[$];
    pair_t m_frame = '0;
    int    m_mc    = 0;
    bit    m_ur    = 1'b0;
    bit    m_hs    = 1'b0;

    always @(posedge mclk or negedge arstn) begin
        if (!arstn) begin
            q.delete();
            m_frame = '0;
            m_mc    = 0;
            m_ur    = 1'b0;
            m_hs    = 1'b0;
        end else begin
            m_hs = sif.s_valid && (q.size() == 0);
            m_ur = 1'b0;
            if (m_hs) q.push_back({sif.s_left, sif.s_right});
            if (m_mc == LRCK - 1) begin
                if (q.size() > 0) m_frame = q.pop_front();
                else begin
                    m_ur = 1'b1;
                    if (!REPEAT) m_frame = '0;
                end
            end
            m_mc = (m_mc + 1) % LRCK;
        end
    end

    function automatic bit exp_sdata(input int mc, input pair_t f);
        int b = mc / SDIV;
        int p;
        logic [SW-1:0] w;
        if (b < SLOT) begin p = b; w = f.l; end
        else begin p = b - SLOT; w = f.r; end
        if (p >= 1 && p <= SW) return w[SW-p];
        return 1'b0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s t=%0t mc=%0d: got %h expected %h", nm, $time, m_mc, act, exp);
        end
    endtask

    always @(negedge mclk) begin
        logic [4:0] e;
        e = {(m_mc >= LRCK/2), ((m_mc % SDIV) >= SDIV/2), exp_sdata(m_mc, m_frame),
             m_ur, (q.size() == 0)};
        check("pins", 32'({lrck, sclk, sdata, underrun, sif.s_ready}), 32'(e));
    end

    task automatic wait_mc(input int k);
        int g = 0;
        @(negedge mclk);
        while (m_mc != k) begin
            @(negedge mclk);
            g++;
            if (g > 2 * LRCK) begin
                vectors++; errs++;
                $display("FAIL wait_mc timeout waiting for mc=%0d", k);
                return;
            end
        end
    endtask

    task automatic send(input logic [SW-1:0] l, input logic [SW-1:0] r);
        int g = 0;
        while (!sif.s_ready) begin
            @(negedge mclk);
            g++;
            if (g > 2 * LRCK) begin
                vectors++; errs++;
                $display("FAIL send timeout waiting for s_ready");
                return;
            end
        end
        sif.s_valid = 1'b1; sif.s_left = l; sif.s_right = r;
        @(negedge mclk);
        sif.s_valid = 1'b0;
    endtask

    vec_t tbl[16];
    int   acc, urc;

    initial begin
        tbl[0]  = '{1,   1'b0, "L b0"};   tbl[1]  = '{5,   1'b1, "L b1"};
        tbl[2]  = '{9,   1'b0, "L b2"};   tbl[3]  = '{49,  1'b0, "L b12"};
        tbl[4]  = '{93,  1'b0, "L b23"};  tbl[5]  = '{97,  1'b1, "L b24"};
        tbl[6]  = '{101, 1'b0, "L b25"};  tbl[7]  = '{125, 1'b0, "L b31"};
        tbl[8]  = '{129, 1'b0, "R p0"};   tbl[9]  = '{133, 1'b0, "R p1"};
        tbl[10] = '{137, 1'b1, "R p2"};   tbl[11] = '{177, 1'b1, "R p12"};
        tbl[12] = '{221, 1'b1, "R p23"};  tbl[13] = '{225, 1'b0, "R p24"};
        tbl[14] = '{229, 1'b0, "R p25"};  tbl[15] = '{253, 1'b0, "R p31"};

        arstn = 1'b0;
        sif.s_valid = 1'b0; sif.s_left = '0; sif.s_right = '0;
        repeat (3) @(negedge mclk);
        check("reset pins", 32'({lrck, sclk, sdata, underrun, sif.s_ready}), 32'b00001);
        arstn = 1'b1;

        // Idle: frame 0 silent, underrun at start of frame 1
        wait_mc(0);
        check("first underrun", 32'(underrun), 32'd1);

        // Sign-pattern pair, checked bit by bit in the following frame
        send(24'h800001, 24'h7FFFFE);
        wait_mc(0);
        for (int i = 0; i < 16; i++) begin
            wait_mc(tbl[i].mc);
            check(tbl[i].nm, 32'(sdata), 32'(tbl[i].exp));
        end

        // Continuous valid: one accept per frame, never starved
        wait_mc(0);
        acc = 0; urc = 0;
        sif.s_valid = 1'b1; sif.s_left = 24'h000100; sif.s_right = 24'hF00100;
        for (int i = 0; i < 4 * LRCK; i++) begin
            if (sif.s_ready) acc++;
            if (i > 0 && underrun) urc++;
            @(negedge mclk);
            if (m_hs) begin
                sif.s_left  = sif.s_left + 24'd1;
                sif.s_right = sif.s_right - 24'd3;
            end
        end
        sif.s_valid = 1'b0;
        check("stream accepts", 32'(acc), 32'd4);
        check("stream underruns", 32'(urc), 32'd0);

        // Random sparse traffic
        for (int i = 0; i < 8 * LRCK; i++) begin
            sif.s_valid = ($urandom_range(0, 150) == 0);
            sif.s_left  = SW'($urandom);
            sif.s_right = SW'($urandom);
            @(negedge mclk);
        end
        sif.s_valid = 1'b0;

        // Handshake on the last cycle of a frame with an empty buffer: bypass
        wait_mc(0);
        wait_mc(LRCK - 1);
        sif.s_valid = 1'b1; sif.s_left = 24'hC00000; sif.s_right = 24'h123456;
        @(negedge mclk);
        sif.s_valid = 1'b0;
        check("bypass no underrun", 32'(underrun), 32'd0);
        wait_mc(5);
        check("bypass left msb", 32'(sdata), 32'd1);

        // Starvation after pair A
        wait_mc(10);
        send(24'hA5A5A5, 24'h5A5A5A);
        urc = 0;
        for (int i = 0; i < 4 * LRCK; i++) begin
            @(negedge mclk);
            if (underrun) urc++;
        end
        check("starve underruns", 32'(urc), 32'd3);
        wait_mc(5);
        check("starve left msb", 32'(sdata), REPEAT ? 32'd1 : 32'd0);

        // Reset mid-frame with a full buffer; the buffered pair must vanish
        send(24'hFFFFFF, 24'hFFFFFF);
        wait_mc(100);
        #1 arstn = 1'b0;
        #1 check("async reset pins", 32'({lrck, sclk, sdata, underrun, sif.s_ready}), 32'b00001);
        repeat (3) @(negedge mclk);
        arstn = 1'b1;
        check("ready after reset", 32'(sif.s_ready), 32'd1);
        wait_mc(0);
        check("post-reset underrun", 32'(underrun), 32'd1);
        wait_mc(5);
        check("discarded pair", 32'(sdata), 32'd0);
        wait_mc(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
`default_nettype wire
